vctr_fetch: RTL

- Downstream stage of the driver: pops test-vector addresses from the address FIFO that the driver fills through addr_fifo_din/addr_fifo_wr.
- For each address, issues one master read, then pushes the returned word into the vector FIFO.
- Produces the addr_fifo_rd and vctr_fifo_wr strobes that the driver monitor counts.
- One read outstanding at a time, with a per-read timeout so a dead slave cannot stall the program.

---
 rtl/vctr_fetch_pkg.sv | 20 ++
 rtl/vctr_fetch_if.sv | 37 +++
 rtl/vctr_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/vctr_fetch_pkg.sv
// Shared types and constants for the vector fetch stage.
package vctr_fetch_pkg;

   // Fetch sequencer states; busy is simply state != IDLE
   typedef enum logic [2:0] {
      IDLE,
      POP,
      LATCH,
      REQ,
      RESP,
      PUSH
   } state_t;

   // Word pushed in place of read data when the slave never answers
   localparam logic [31:0] TIMEOUT_PATTERN_DEF = 32'hDEAD_BEEF;

   // Counter width shared with the driver's cycle-count outputs
   localparam int CNT_W = 16;

endpackage

// File: rtl/vctr_fetch_if.sv
// Address FIFO read side, master read bus and vector FIFO write side.
interface vctr_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  addr_fifo_empty;
   logic [ADDR_WIDTH-1:0] addr_fifo_dout;
   logic                  addr_fifo_rd;

   logic [ADDR_WIDTH-1:0] master_addr;
   logic                  master_rd;
   logic                  master_wait;
   logic [DATA_WIDTH-1:0] master_data_in;
   logic                  master_data_in_val;

   logic                  vctr_fifo_full;
   logic [DATA_WIDTH-1:0] vctr_fifo_din;
   logic                  vctr_fifo_wr;

   // Fetch engine side
   modport master (
      input  addr_fifo_empty, addr_fifo_dout,
      input  master_wait, master_data_in, master_data_in_val,
      input  vctr_fifo_full,
      output addr_fifo_rd, master_addr, master_rd,
      output vctr_fifo_din, vctr_fifo_wr
   );

   // FIFOs / slave side
   modport slave (
      output addr_fifo_empty, addr_fifo_dout,
      output master_wait, master_data_in, master_data_in_val,
      output vctr_fifo_full,
      input  addr_fifo_rd, master_addr, master_rd,
      input  vctr_fifo_din, vctr_fifo_wr
   );
endinterface

// File: rtl/vctr_fetch.sv
// Pops an address, performs one master read (with timeout), pushes the word.
module vctr_fetch
   import vctr_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    TIMEOUT_CYCLES  = 256,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_PATTERN = DATA_WIDTH'(TIMEOUT_PATTERN_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_program,
   vctr_fetch_if.master     bus,
   output logic             busy,
   output logic             rd_timeout,
   output logic [CNT_W-1:0] fetch_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [TW-1:0]         timer;
   logic [CNT_W-1:0]      cnt_q;
   logic                  timer_done;

   assign timer_done = (timer == TW'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: one read outstanding; full is only checked at IDLE since
   // nothing else writes the vector FIFO, so a slot is still free at PUSH
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (run_program && !bus.addr_fifo_empty && !bus.vctr_fifo_full)
                     state_nx = POP;
         POP:     state_nx = LATCH;
         LATCH:   state_nx = REQ;
         REQ:     if (!bus.master_wait) state_nx = RESP;
         RESP:    if (bus.master_data_in_val || timer_done) state_nx = PUSH;
         PUSH:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode from the state register only, never from inputs
   always_comb begin
      bus.addr_fifo_rd = (state == POP);
      bus.master_rd    = (state == REQ);
      bus.vctr_fifo_wr = (state == PUSH);
      busy             = (state != IDLE);
   end

   assign bus.master_addr   = addr_q;
   assign bus.vctr_fifo_din = data_q;
   assign fetch_cnt         = cnt_q;

   // Datapath: address latch, response capture, timeout timer, counters.
   // A valid arriving on the expiry cycle wins over the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         data_q     <= '0;
         timer      <= '0;
         rd_timeout <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state)
            LATCH: addr_q <= bus.addr_fifo_dout;
            REQ:   if (!bus.master_wait) timer <= '0;
            RESP: begin
               if (bus.master_data_in_val) begin
                  data_q <= bus.master_data_in;
               end else if (timer_done) begin
                  data_q     <= TIMEOUT_PATTERN;
                  rd_timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PUSH:    cnt_q <= cnt_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
